sio_l2b_ret_asm: RTL and testbench
==================================

# sio_l2b_ret_asm

Per-bank return-path assembler in the SIO, directly downstream of one L2 bank's `l2bN_sio_*` outbound interface. It captures the header beat marked by `ctag_vld`, and collects the 16 following 32-bit data beats for read returns. It checks per-halfword parity, accumulates uncorrectable-error status, and queues completed returns in a small FIFO. Entries are presented to the SIO egress arbiter over a valid/ready handshake, and a credit is returned to the L2 bank on each dequeue. One instance is placed per bank (eight total).

## Interface
- `DEPTH`, 2: FIFO entries; power of 2, ≥2.
- `iol2clk`  in  1  I/O-L2 clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `l2b_sio_ctag_vld`  in  1  header beat strobe.
- `l2b_sio_data`  in  32  header or data beat.
- `l2b_sio_parity`  in  2  even parity: [1] over data[31:16], [0] over data[15:0].
- `l2b_sio_ue_err`  in  1  uncorrectable error for the current beat.
- `ret_vld`  out  1  FIFO head valid.
- `ret_rdy`  in  1  consumer accepts head.
- `ret_ctag`  out  16  head ctag.
- `ret_has_data`  out  1  head is a read return.
- `ret_data`  out  512  head line; beat k occupies [511-32k -: 32]; zero when `ret_has_data`=0.
- `ret_ue`  out  1  any `ue_err` seen during the transfer.
- `ret_pe`  out  1  any parity mismatch during the transfer, header included.
- `sio_l2b_credit`  out  1  one-cycle pulse per dequeue.
- `ovf_err`  out  1  sticky: a completed return was dropped because the FIFO was full.
- `proto_err`  out  1  sticky: `ctag_vld` seen during the data phase.

## Operation
- Header beat, when `ctag_vld`=1 in IDLE:
  - data[15:0] = ctag.
  - data[16] = has_data: 1 for read, 0 for WR8/WRI ack.
  - data[31:17] ignored, but covered by the parity check.
- FSM states: IDLE and DATA.
  - IDLE, `ctag_vld`=1, has_data=0: the entry is complete this cycle; push it; stay IDLE.
  - IDLE, `ctag_vld`=1, has_data=1: latch ctag; clear the ue/pe accumulators to this beat's values; `beat_cnt` ← 0; go to DATA.
  - DATA: every cycle is a data beat. Write beat `beat_cnt` into the line buffer, OR in ue/pe, and increment `beat_cnt` (4 bits).
  - DATA, `beat_cnt`=15: push the entry; go to IDLE.
- `ctag_vld`=1 in DATA: the beat is still consumed as data, and `proto_err` sets. There is no restart.
- Parity mismatch: `l2b_sio_parity[i]` ≠ XOR of the matching 16-bit half.
- Push when the FIFO is full and there is no same-cycle pop: the entry is dropped, `ovf_err` sets, and no credit is issued.
- Push and pop in the same cycle when full: the push is accepted.
- Pop when `ret_vld && ret_rdy`. `sio_l2b_credit` pulses on the following cycle.
- FIFO pointers are `log2(DEPTH)`+1 bits and wrap naturally. Full means the MSBs differ and the rest are equal.
- Output fields come straight from the FIFO head register; there is no combinational path from `l2b_*` to `ret_*`.

## Timing
- Reset, asynchronous:
  - FSM in IDLE, `beat_cnt`=0, FIFO empty.
  - All outputs 0, including `ovf_err` and `proto_err`.
  - A transfer in progress is discarded with no credit. Inputs are ignored until the first edge after `rst` deasserts.
- Ack with header at cycle T: `ret_vld`=1 at T+1, if the FIFO was empty.
- Read with header at T: data beats at T+1..T+16; `ret_vld`=1 at T+17.
- Back-to-back transfers are allowed. A header may arrive in the cycle after beat 15.
- `ret_*` are stable while `ret_vld`=1 and `ret_rdy`=0.
- Sticky errors clear only on reset.

## Test plan
- WR8 ack: header 0x0000_1234 with correct parity at T.
  - Required: `ret_vld` at T+1, `ret_ctag`=0x1234, `ret_has_data`=0, `ret_data`=0, `ret_ue`=`ret_pe`=0.
  - Then pulse `ret_rdy`: `sio_l2b_credit` is 1 for exactly one cycle.
- Read: header 0x0001_00AB, then beats 0x0000_0000..0x0000_000F.
  - Required: `ret_vld` at T+17, `ret_ctag`=0x00AB, `ret_data`[511:480]=0, `ret_data`[31:0]=0xF.
- Errors: a read with `ue_err`=1 only on beat 9 and a flipped `parity[1]` on beat 3.
  - Required: `ret_ue`=1, `ret_pe`=1. The next clean transfer shows both 0.
- Overflow: hold `ret_rdy`=0 and send three acks with ctags 1, 2, 3 (`DEPTH`=2).
  - Required: `ovf_err`=1; the FIFO holds ctags 1 and 2; draining yields exactly two credits.
  - Repeat with a full FIFO and `ret_rdy`=1 in the push cycle: the push is accepted and `ovf_err` stays 0.
- Protocol and reset:
  - `ctag_vld` at beat 5 of a read: `proto_err`=1, and the line completes at T+17 with 16 beats.
  - Assert `rst` at beat 8 of a read: all outputs are 0 immediately; a subsequent ack completes normally.

Source files
------------

// File: rtl/sio_l2b_ret_asm.sv
// Return-path assembler for one L2 bank: collects header + 16 data beats,
// checks parity, queues completed returns and issues one credit per dequeue.
module sio_l2b_ret_asm #(
  parameter int DEPTH = 2
) (
  input  logic         iol2clk,
  input  logic         rst,
  input  logic         l2b_sio_ctag_vld,
  input  logic [31:0]  l2b_sio_data,
  input  logic [1:0]   l2b_sio_parity,
  input  logic         l2b_sio_ue_err,
  output logic         ret_vld,
  input  logic         ret_rdy,
  output logic [15:0]  ret_ctag,
  output logic         ret_has_data,
  output logic [511:0] ret_data,
  output logic         ret_ue,
  output logic         ret_pe,
  output logic         sio_l2b_credit,
  output logic         ovf_err,
  output logic         proto_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_IDLE, ST_DATA} state_t;

  state_t        state_q, state_d;
  logic [3:0]    beat_cnt_q, beat_cnt_d;
  logic [511:0]  line_q, line_d;
  logic [15:0]   ctag_q;
  logic          ue_acc_q, pe_acc_q;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          credit_q, ovf_q, proto_q;

  logic [15:0]   mem_ctag_q [DEPTH];
  logic          mem_hd_q   [DEPTH];
  logic [511:0]  mem_data_q [DEPTH];
  logic          mem_ue_q   [DEPTH];
  logic          mem_pe_q   [DEPTH];

  logic          beat_pe;
  logic          push, push_ok, pop, full, proto_set;
  logic          push_hd, push_ue, push_pe;
  logic [15:0]   push_ctag;
  logic [511:0]  push_data;

  function automatic logic par_mismatch(input logic [31:0] d, input logic [1:0] p);
    return ((^d[31:16]) != p[1]) || ((^d[15:0]) != p[0]);
  endfunction

  assign beat_pe = par_mismatch(l2b_sio_data, l2b_sio_parity);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    line_d     = line_q;
    push       = 1'b0;
    push_ctag  = ctag_q;
    push_hd    = 1'b0;
    push_data  = '0;
    push_ue    = 1'b0;
    push_pe    = 1'b0;
    proto_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (l2b_sio_ctag_vld) begin
          beat_cnt_d = 4'd0;
          if (l2b_sio_data[16]) begin
            state_d = ST_DATA;
          end else begin
            push      = 1'b1;
            push_ctag = l2b_sio_data[15:0];
            push_ue   = l2b_sio_ue_err;
            push_pe   = beat_pe;
          end
        end
      end
      ST_DATA: begin
        // A header strobe here is consumed as an ordinary data beat.
        line_d[9'd511 - {beat_cnt_q, 5'd0} -: 32] = l2b_sio_data;
        beat_cnt_d = beat_cnt_q + 4'd1;
        proto_set  = l2b_sio_ctag_vld;
        if (beat_cnt_q == 4'd15) begin
          push      = 1'b1;
          push_hd   = 1'b1;
          push_data = line_d;
          push_ue   = ue_acc_q | l2b_sio_ue_err;
          push_pe   = pe_acc_q | beat_pe;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ret_vld = (wr_ptr_q != rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = ret_vld && ret_rdy;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 4'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      credit_q   <= 1'b0;
      ovf_q      <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      credit_q   <= pop;
      if (push_ok)         wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)             rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !push_ok) ovf_q   <= 1'b1;
      if (proto_set)       proto_q  <= 1'b1;
    end
  end

  // Datapath storage carries no reset; visibility is governed by the pointers.
  always_ff @(posedge iol2clk) begin
    line_q <= line_d;
    if (state_q == ST_IDLE && l2b_sio_ctag_vld && l2b_sio_data[16]) begin
      ctag_q   <= l2b_sio_data[15:0];
      ue_acc_q <= l2b_sio_ue_err;
      pe_acc_q <= beat_pe;
    end else if (state_q == ST_DATA) begin
      ue_acc_q <= ue_acc_q | l2b_sio_ue_err;
      pe_acc_q <= pe_acc_q | beat_pe;
    end
    if (push_ok) begin
      mem_ctag_q[wr_ptr_q[AW-1:0]] <= push_ctag;
      mem_hd_q[wr_ptr_q[AW-1:0]]   <= push_hd;
      mem_data_q[wr_ptr_q[AW-1:0]] <= push_data;
      mem_ue_q[wr_ptr_q[AW-1:0]]   <= push_ue;
      mem_pe_q[wr_ptr_q[AW-1:0]]   <= push_pe;
    end
  end

  assign ret_ctag       = ret_vld ? mem_ctag_q[rd_ptr_q[AW-1:0]] : '0;
  assign ret_has_data   = ret_vld ? mem_hd_q[rd_ptr_q[AW-1:0]]   : 1'b0;
  assign ret_data       = ret_vld ? mem_data_q[rd_ptr_q[AW-1:0]] : '0;
  assign ret_ue         = ret_vld ? mem_ue_q[rd_ptr_q[AW-1:0]]   : 1'b0;
  assign ret_pe         = ret_vld ? mem_pe_q[rd_ptr_q[AW-1:0]]   : 1'b0;
  assign sio_l2b_credit = credit_q;
  assign ovf_err        = ovf_q;
  assign proto_err      = proto_q;

endmodule

// File: tb/tb_sio_l2b_ret_asm.sv
// Bench for sio_l2b_ret_asm: directed transfers, a queue-based reference of
// completed returns, and literal spot checks on the key scenarios.
module tb_sio_l2b_ret_asm;
  localparam int DEPTH = 2;

  logic         iol2clk = 1'b0;
  logic         rst = 1'b0;
  logic         ctag_vld = 1'b0;
  logic [31:0]  l2b_data = '0;
  logic [1:0]   l2b_par = '0;
  logic         l2b_ue = 1'b0;
  logic         ret_rdy = 1'b0;
  logic         ret_vld, ret_has_data, ret_ue, ret_pe, sio_l2b_credit, ovf_err, proto_err;
  logic [15:0]  ret_ctag;
  logic [511:0] ret_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]  ctag;
    logic         hd;
    logic [511:0] data;
    logic         ue;
    logic         pe;
  } ent_t;

  ent_t q[$];
  ent_t pend;
  logic pend_vld = 1'b0;
  logic proto_pend = 1'b0;
  logic exp_credit = 1'b0;
  logic exp_ovf = 1'b0;
  logic exp_proto = 1'b0;
  logic cmp_en = 1'b0;

  sio_l2b_ret_asm #(.DEPTH(DEPTH)) dut (
    .iol2clk(iol2clk), .rst(rst),
    .l2b_sio_ctag_vld(ctag_vld), .l2b_sio_data(l2b_data),
    .l2b_sio_parity(l2b_par), .l2b_sio_ue_err(l2b_ue),
    .ret_vld(ret_vld), .ret_rdy(ret_rdy), .ret_ctag(ret_ctag),
    .ret_has_data(ret_has_data), .ret_data(ret_data), .ret_ue(ret_ue),
    .ret_pe(ret_pe), .sio_l2b_credit(sio_l2b_credit),
    .ovf_err(ovf_err), .proto_err(proto_err)
  );

  always #5 iol2clk = ~iol2clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] gp(input logic [31:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

  function automatic logic [31:0] beat_val(input logic [7:0] seed, input int k);
    logic [3:0] k4;
    k4 = 4'(k);
    if (seed == 8'h00) return 32'(k);
    return {seed, 4'h0, k4, ~seed, k4, 4'hC};
  endfunction

  // Reference: completed returns enter a bounded queue; a pop frees room first.
  always @(posedge iol2clk) begin
    logic popped;
    if (!rst) begin
      popped = (q.size() > 0) && ret_rdy;
      if (popped) void'(q.pop_front());
      exp_credit = popped;
      if (pend_vld) begin
        if (q.size() < DEPTH) q.push_back(pend);
        else exp_ovf = 1'b1;
        pend_vld = 1'b0;
      end
      if (proto_pend) begin
        exp_proto = 1'b1;
        proto_pend = 1'b0;
      end
    end
  end

  always @(negedge iol2clk) begin
    if (cmp_en) begin
      chk("ret_vld", 512'(ret_vld), 512'(q.size() > 0));
      if (q.size() > 0) begin
        chk("ret_ctag", 512'(ret_ctag), 512'(q[0].ctag));
        chk("ret_has_data", 512'(ret_has_data), 512'(q[0].hd));
        chk("ret_data", ret_data, q[0].data);
        chk("ret_ue", 512'(ret_ue), 512'(q[0].ue));
        chk("ret_pe", 512'(ret_pe), 512'(q[0].pe));
      end
      chk("credit", 512'(sio_l2b_credit), 512'(exp_credit));
      chk("ovf_err", 512'(ovf_err), 512'(exp_ovf));
      chk("proto_err", 512'(proto_err), 512'(exp_proto));
    end
  end

  task automatic tick();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic idle_inputs();
    ctag_vld = 1'b0;
    l2b_data = '0;
    l2b_par  = '0;
    l2b_ue   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    q.delete();
    pend_vld = 1'b0;
    proto_pend = 1'b0;
    exp_credit = 1'b0;
    exp_ovf = 1'b0;
    exp_proto = 1'b0;
    #1;
    chk("rst_vld", 512'(ret_vld), 512'(0));
    chk("rst_ctag", 512'(ret_ctag), 512'(0));
    chk("rst_hd", 512'(ret_has_data), 512'(0));
    chk("rst_data", ret_data, 512'(0));
    chk("rst_ue_pe", 512'({ret_ue, ret_pe}), 512'(0));
    chk("rst_credit", 512'(sio_l2b_credit), 512'(0));
    chk("rst_sticky", 512'({ovf_err, proto_err}), 512'(0));
    repeat (2) @(posedge iol2clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_ack(input logic [15:0] ctag, input logic [14:0] hi,
                          input logic [1:0] flip, input logic ue_v);
    ctag_vld = 1'b1;
    l2b_data = {hi, 1'b0, ctag};
    l2b_par  = gp({hi, 1'b0, ctag}) ^ flip;
    l2b_ue   = ue_v;
    pend.ctag = ctag;
    pend.hd   = 1'b0;
    pend.data = '0;
    pend.ue   = ue_v;
    pend.pe   = (flip != 2'b00);
    pend_vld  = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic send_read(input logic [15:0] ctag, input logic [7:0] seed,
                           input int ue_beat, input int pe_beat, input int proto_beat);
    logic [511:0] line;
    logic [31:0]  b;
    logic         uea, pea;
    ctag_vld = 1'b1;
    l2b_data = {15'h0, 1'b1, ctag};
    l2b_par  = gp({15'h0, 1'b1, ctag});
    l2b_ue   = 1'b0;
    tick();
    line = '0;
    uea = 1'b0;
    pea = 1'b0;
    for (int k = 0; k < 16; k++) begin
      b = beat_val(seed, k);
      ctag_vld = (k == proto_beat);
      l2b_data = b;
      l2b_par  = gp(b) ^ ((k == pe_beat) ? 2'b10 : 2'b00);
      l2b_ue   = (k == ue_beat);
      line[511 - 32*k -: 32] = b;
      uea = uea | (k == ue_beat);
      pea = pea | (k == pe_beat);
      if (k == proto_beat) proto_pend = 1'b1;
      if (k == 15) begin
        pend.ctag = ctag;
        pend.hd   = 1'b1;
        pend.data = line;
        pend.ue   = uea;
        pend.pe   = pea;
        pend_vld  = 1'b1;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic drain(input int n, output int credits);
    credits = 0;
    ret_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sio_l2b_credit) credits++;
    end
    ret_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (sio_l2b_credit) credits++;
    end
  endtask

  initial begin
    int cr;
    #2;
    do_reset();
    cmp_en = 1'b1;
    tick();

    // WR8 ack and single-cycle credit
    send_ack(16'h1234, 15'h0, 2'b00, 1'b0);
    chk("ack_vld", 512'(ret_vld), 512'(1));
    chk("ack_ctag", 512'(ret_ctag), 512'(16'h1234));
    chk("ack_hd", 512'(ret_has_data), 512'(0));
    chk("ack_data", ret_data, 512'(0));
    chk("ack_ue_pe", 512'({ret_ue, ret_pe}), 512'(0));
    ret_rdy = 1'b1;
    tick();
    ret_rdy = 1'b0;
    chk("credit_hi", 512'(sio_l2b_credit), 512'(1));
    tick();
    chk("credit_lo", 512'(sio_l2b_credit), 512'(0));

    // Read with beats 0..F
    send_read(16'h00AB, 8'h00, -1, -1, -1);
    chk("rd_vld", 512'(ret_vld), 512'(1));
    chk("rd_ctag", 512'(ret_ctag), 512'(16'h00AB));
    chk("rd_hd", 512'(ret_has_data), 512'(1));
    chk("rd_beat0", 512'(ret_data[511:480]), 512'(0));
    chk("rd_beat15", 512'(ret_data[31:0]), 512'(32'hF));
    chk("rd_beat1", 512'(ret_data[479:448]), 512'(32'h1));
    drain(2, cr);

    // Error accumulation, then a clean transfer
    send_read(16'h0055, 8'h3C, 9, 3, -1);
    chk("err_ue", 512'(ret_ue), 512'(1));
    chk("err_pe", 512'(ret_pe), 512'(1));
    drain(2, cr);
    send_read(16'h0056, 8'h71, -1, -1, -1);
    chk("clean_ue_pe", 512'({ret_ue, ret_pe}), 512'(0));
    drain(2, cr);

    // Header parity error and ue on an ack
    send_ack(16'h0042, 15'h2AAA, 2'b01, 1'b1);
    chk("hdr_pe", 512'(ret_pe), 512'(1));
    chk("hdr_ue", 512'(ret_ue), 512'(1));
    drain(2, cr);

    // Overflow with ret_rdy held low
    send_ack(16'h0001, 15'h0, 2'b00, 1'b0);
    send_ack(16'h0002, 15'h0, 2'b00, 1'b0);
    send_ack(16'h0003, 15'h0, 2'b00, 1'b0);
    chk("ovf_set", 512'(ovf_err), 512'(1));
    chk("ovf_head", 512'(ret_ctag), 512'(16'h0001));
    drain(6, cr);
    chk("ovf_credits", 512'(cr), 512'(2));
    chk("ovf_empty", 512'(ret_vld), 512'(0));

    // Full FIFO with a same-cycle pop accepts the push
    do_reset();
    send_ack(16'h0004, 15'h0, 2'b00, 1'b0);
    send_ack(16'h0005, 15'h0, 2'b00, 1'b0);
    ret_rdy = 1'b1;
    send_ack(16'h0006, 15'h0, 2'b00, 1'b0);
    ret_rdy = 1'b0;
    chk("fullpop_ovf", 512'(ovf_err), 512'(0));
    chk("fullpop_head", 512'(ret_ctag), 512'(16'h0005));
    drain(4, cr);
    chk("fullpop_credits", 512'(cr), 512'(2));

    // ctag_vld mid-read, then a back-to-back ack
    send_read(16'h0D0D, 8'h99, -1, -1, 5);
    chk("proto_set", 512'(proto_err), 512'(1));
    chk("proto_vld", 512'(ret_vld), 512'(1));
    chk("proto_ctag", 512'(ret_ctag), 512'(16'h0D0D));
    send_ack(16'h0E0E, 15'h1111, 2'b00, 1'b0);

    // Reset during beat 8 of a read with FIFO full and proto_err set
    ctag_vld = 1'b1;
    l2b_data = {15'h0, 1'b1, 16'h0BAD};
    l2b_par  = gp({15'h0, 1'b1, 16'h0BAD});
    tick();
    for (int k = 0; k < 8; k++) begin
      ctag_vld = 1'b0;
      l2b_data = beat_val(8'h21, k);
      l2b_par  = gp(beat_val(8'h21, k));
      tick();
    end
    l2b_data = beat_val(8'h21, 8);
    l2b_par  = gp(beat_val(8'h21, 8));
    do_reset();
    send_ack(16'h00C3, 15'h0, 2'b00, 1'b0);
    chk("post_rst_vld", 512'(ret_vld), 512'(1));
    chk("post_rst_ctag", 512'(ret_ctag), 512'(16'h00C3));
    drain(2, cr);
    chk("post_rst_credits", 512'(cr), 512'(1));

    // Back-to-back reads with the consumer always ready
    ret_rdy = 1'b1;
    send_read(16'hBEEF, 8'h5A, 15, 0, -1);
    send_read(16'hCAFE, 8'hE7, -1, -1, -1);
    ret_rdy = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
